// File: rtl/pll_dyn_ctrl.sv
// Loop-filter profile sequencer for a GW5A PLL with dynamic ICP/LPF selection.
// Applies a profile, pulses PLL reset, qualifies lock, retries/falls back, and re-locks on loss.
module pll_dyn_ctrl #(
    parameter int unsigned NUM_CFG      = 4,
    parameter logic [11*NUM_CFG-1:0] CFG_TABLE = {6'd8,  3'd4, 2'd2,
                                                  6'd28, 3'd1, 2'd1,
                                                  6'd12, 3'd3, 2'd0,
                                                  6'd20, 3'd2, 2'd0},
    parameter int unsigned RESET_CYCLES = 64,
    parameter int unsigned LOCK_TIMEOUT = 65536,
    parameter int unsigned LOCK_STABLE  = 256,
    parameter int unsigned MAX_RETRY    = 2,
    localparam int unsigned CW = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1
) (
    input  logic          clkin,
    input  logic          reset,
    input  logic          pll_lock,
    output logic          pll_reset,
    output logic [5:0]    icpsel,
    output logic [2:0]    lpfres,
    output logic [1:0]    lpfcap,
    input  logic          cfg_req,
    input  logic [CW-1:0] cfg_sel,
    output logic [CW-1:0] cur_cfg,
    output logic          busy,
    output logic          locked,
    output logic          fail,
    output logic [7:0]    relock_cnt
);

    localparam int unsigned TMAX_A = (RESET_CYCLES > LOCK_STABLE) ? RESET_CYCLES : LOCK_STABLE;
    localparam int unsigned TMAX   = (LOCK_TIMEOUT > TMAX_A) ? LOCK_TIMEOUT : TMAX_A;
    localparam int unsigned TW     = $clog2(TMAX + 1);
    localparam int unsigned RW     = $clog2(MAX_RETRY + 1);
    localparam int unsigned TRW    = $clog2(NUM_CFG * MAX_RETRY + 1);

    localparam logic [TW-1:0]  RST_LAST  = TW'(RESET_CYCLES - 1);
    localparam logic [TW-1:0]  TO_LAST   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0]  STB_LAST  = TW'(LOCK_STABLE - 1);
    localparam logic [RW-1:0]  RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [TRW-1:0] TRIES_MAX = TRW'(NUM_CFG * MAX_RETRY);
    localparam logic [CW-1:0]  CFG_LAST  = CW'(NUM_CFG - 1);
    localparam logic [10:0]    CFG0      = CFG_TABLE[10:0];

    typedef enum logic [2:0] {
        S_RST,
        S_WAIT,
        S_STABLE,
        S_LOCKED,
        S_FAILTRY,
        S_FAIL
    } state_t;

    state_t         state, state_nxt;
    logic [TW-1:0]  timer, timer_nxt;
    logic [RW-1:0]  retry, retry_nxt, retry_inc;
    logic [TRW-1:0] tries, tries_nxt, tries_inc;
    logic [CW-1:0]  cfg_nxt, cfg_wrap, sel_clip;
    logic           relock_inc;
    logic           lock_s1, lock_s;
    logic [10:0]    cfg_rom [NUM_CFG];

    for (genvar g = 0; g < NUM_CFG; g++) begin : g_rom
        assign cfg_rom[g] = CFG_TABLE[11*g +: 11];
    end

    if ((1 << CW) > NUM_CFG) begin : g_clip
        assign sel_clip = (cfg_sel > CFG_LAST) ? CFG_LAST : cfg_sel;
    end else begin : g_noclip
        assign sel_clip = cfg_sel;
    end

    assign cfg_wrap  = (cur_cfg == CFG_LAST) ? '0 : cur_cfg + CW'(1);
    assign retry_inc = retry + RW'(1);
    assign tries_inc = tries + TRW'(1);

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            lock_s1 <= 1'b0;
            lock_s  <= 1'b0;
            state   <= S_RST;
            timer   <= '0;
            retry   <= '0;
            tries   <= '0;
        end else begin
            lock_s1 <= pll_lock;
            lock_s  <= lock_s1;
            state   <= state_nxt;
            timer   <= timer_nxt;
            retry   <= retry_nxt;
            tries   <= tries_nxt;
        end
    end

    // timer is shared: reset pulse width, lock wait timeout, then stable-lock count
    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        retry_nxt  = retry;
        tries_nxt  = tries;
        cfg_nxt    = cur_cfg;
        relock_inc = 1'b0;
        if (cfg_req) begin
            state_nxt = S_RST;
            timer_nxt = '0;
            retry_nxt = '0;
            tries_nxt = '0;
            cfg_nxt   = sel_clip;
        end else begin
            case (state)
                S_RST: begin
                    if (timer == RST_LAST) begin
                        state_nxt = S_WAIT;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer + TW'(1);
                    end
                end
                S_WAIT: begin
                    if (lock_s) begin
                        state_nxt = S_STABLE;
                        timer_nxt = '0;
                    end else if (timer == TO_LAST) begin
                        state_nxt = S_FAILTRY;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer + TW'(1);
                    end
                end
                S_STABLE: begin
                    if (!lock_s) begin
                        state_nxt = S_FAILTRY;
                        timer_nxt = '0;
                    end else if (timer == STB_LAST) begin
                        state_nxt = S_LOCKED;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer + TW'(1);
                    end
                end
                S_LOCKED: begin
                    if (!lock_s) begin
                        relock_inc = 1'b1;
                        retry_nxt  = '0;
                        tries_nxt  = '0;
                        timer_nxt  = '0;
                        state_nxt  = S_RST;
                    end
                end
                S_FAILTRY: begin
                    tries_nxt = tries_inc;
                    retry_nxt = retry_inc;
                    timer_nxt = '0;
                    if (tries_inc == TRIES_MAX) begin
                        state_nxt = S_FAIL;
                    end else begin
                        if (retry_inc == RETRY_MAX) begin
                            cfg_nxt   = cfg_wrap;
                            retry_nxt = '0;
                        end
                        state_nxt = S_RST;
                    end
                end
                S_FAIL: begin
                    state_nxt = S_FAIL;
                end
                default: begin
                    state_nxt = S_RST;
                    timer_nxt = '0;
                end
            endcase
        end
    end

    // Outputs follow the next state so the profile is in place on the cycle RST is entered.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            pll_reset                <= 1'b1;
            {icpsel, lpfres, lpfcap} <= CFG0;
            cur_cfg                  <= '0;
            busy                     <= 1'b1;
            locked                   <= 1'b0;
            fail                     <= 1'b0;
            relock_cnt               <= '0;
        end else begin
            cur_cfg   <= cfg_nxt;
            pll_reset <= (state_nxt == S_RST) || (state_nxt == S_FAIL);
            busy      <= !((state_nxt == S_LOCKED) || (state_nxt == S_FAIL));
            locked    <= (state_nxt == S_LOCKED);
            fail      <= (state_nxt == S_FAIL);
            if (state_nxt == S_RST) begin
                {icpsel, lpfres, lpfcap} <= cfg_rom[cfg_nxt];
            end
            if (relock_inc && (relock_cnt != 8'hFF)) begin
                relock_cnt <= relock_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Bench for pll_dyn_ctrl: directed scenarios plus randomized lock behaviour,
// every cycle compared against a phase/countdown reference model.
module tb_pll_dyn_ctrl;

    localparam int RC = 4, LT = 32, LS = 8, MR = 2, N = 4;

    logic       clkin = 1'b0, reset = 1'b1, pll_lock = 1'b0, cfg_req = 1'b0;
    logic [1:0] cfg_sel = '0;
    logic       pll_reset, busy, locked, fail;
    logic [5:0] icpsel;
    logic [2:0] lpfres;
    logic [1:0] lpfcap, cur_cfg;
    logic [7:0] relock_cnt;

    int errors = 0, checks = 0;
    int lock_mode = 0;  // 0 fixed value, 1 lock follows !pll_reset, 2 same with dropouts, 3 noise
    bit lock_val = 1'b0;
    int drop_pct = 2;

    always #5 clkin = ~clkin;

    pll_dyn_ctrl #(
        .NUM_CFG(N), .RESET_CYCLES(RC), .LOCK_TIMEOUT(LT), .LOCK_STABLE(LS), .MAX_RETRY(MR)
    ) dut (
        .clkin(clkin), .reset(reset), .pll_lock(pll_lock), .pll_reset(pll_reset),
        .icpsel(icpsel), .lpfres(lpfres), .lpfcap(lpfcap), .cfg_req(cfg_req),
        .cfg_sel(cfg_sel), .cur_cfg(cur_cfg), .busy(busy), .locked(locked),
        .fail(fail), .relock_cnt(relock_cnt)
    );

    // ---------------- reference model ----------------
    localparam int P_RST = 0, P_WAIT = 1, P_STB = 2, P_LKD = 3, P_FTRY = 4, P_FAIL = 5;
    int          m_ph, m_rem, m_cfg, m_retry, m_tries, m_relock;
    bit          m_s1, m_s2;
    logic [10:0] m_prof;

    function automatic logic [10:0] prof(input int i);
        case (i)
            0: return {6'd20, 3'd2, 2'd0};
            1: return {6'd12, 3'd3, 2'd0};
            2: return {6'd28, 3'd1, 2'd1};
            default: return {6'd8, 3'd4, 2'd2};
        endcase
    endfunction

    task automatic m_enter_rst();
        m_ph = P_RST; m_rem = RC; m_prof = prof(m_cfg);
    endtask

    task automatic m_init();
        m_cfg = 0; m_retry = 0; m_tries = 0; m_relock = 0; m_s1 = 0; m_s2 = 0;
        m_enter_rst();
    endtask

    task automatic m_step();
        bit ls;
        ls = m_s2; m_s2 = m_s1; m_s1 = pll_lock;
        if (cfg_req) begin
            m_cfg = (int'(cfg_sel) >= N) ? N - 1 : int'(cfg_sel);
            m_retry = 0; m_tries = 0;
            m_enter_rst();
        end else begin
            case (m_ph)
                P_RST: begin
                    m_rem = m_rem - 1;
                    if (m_rem == 0) begin m_ph = P_WAIT; m_rem = LT; end
                end
                P_WAIT: begin
                    if (ls) begin m_ph = P_STB; m_rem = LS; end
                    else begin m_rem = m_rem - 1; if (m_rem == 0) m_ph = P_FTRY; end
                end
                P_STB: begin
                    if (!ls) m_ph = P_FTRY;
                    else begin m_rem = m_rem - 1; if (m_rem == 0) m_ph = P_LKD; end
                end
                P_LKD: begin
                    if (!ls) begin
                        if (m_relock < 255) m_relock = m_relock + 1;
                        m_retry = 0; m_tries = 0;
                        m_enter_rst();
                    end
                end
                P_FTRY: begin
                    m_retry = m_retry + 1; m_tries = m_tries + 1;
                    if (m_tries == N * MR) m_ph = P_FAIL;
                    else begin
                        if (m_retry == MR) begin m_cfg = (m_cfg + 1) % N; m_retry = 0; end
                        m_enter_rst();
                    end
                end
                default: ;
            endcase
        end
    endtask

    always @(posedge clkin or posedge reset) begin
        if (reset) m_init();
        else m_step();
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_model();
        chk("pll_reset", 32'(pll_reset), 32'(m_ph == P_RST || m_ph == P_FAIL));
        chk("busy", 32'(busy), 32'(!(m_ph == P_LKD || m_ph == P_FAIL)));
        chk("locked", 32'(locked), 32'(m_ph == P_LKD));
        chk("fail", 32'(fail), 32'(m_ph == P_FAIL));
        chk("icpsel", 32'(icpsel), 32'(m_prof[10:5]));
        chk("lpfres", 32'(lpfres), 32'(m_prof[4:2]));
        chk("lpfcap", 32'(lpfcap), 32'(m_prof[1:0]));
        chk("cur_cfg", 32'(cur_cfg), 32'(m_cfg));
        chk("relock_cnt", 32'(relock_cnt), 32'(m_relock));
    endtask

    task automatic tick();
        @(negedge clkin);
        check_model();
        cfg_req = 1'b0;
        case (lock_mode)
            0: pll_lock = lock_val;
            1: pll_lock = !pll_reset;
            2: pll_lock = !pll_reset && ($urandom_range(0, 99) >= drop_pct);
            default: pll_lock = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic pulse_width(output int n);
        n = 0;
        while (pll_reset === 1'b1 && n < 50) begin n++; tick(); end
    endtask

    task automatic wait_locked(output int m);
        m = 0;
        while (locked !== 1'b1 && m < 60) begin tick(); m++; end
        chk("lock_reached", 32'(locked), 32'd1);
    endtask

    task automatic wait_rst();
        int k;
        k = 0;
        while (pll_reset !== 1'b1 && k < 60) begin tick(); k++; end
        chk("rst_seen", 32'(pll_reset), 32'd1);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        @(negedge clkin);
        reset = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, m, low;
        int exp_icp [8] = '{20, 20, 12, 12, 28, 28, 8, 8};

        // Power-up: reset values, 4-cycle pulse, lock 2+8+1 cycles after release of PLL reset
        lock_mode = 1;
        repeat (3) @(negedge clkin);
        check_model();
        chk("rst_pll_reset", 32'(pll_reset), 32'd1);
        chk("rst_icpsel", 32'(icpsel), 32'd20);
        chk("rst_lpfres", 32'(lpfres), 32'd2);
        chk("rst_lpfcap", 32'(lpfcap), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_fail", 32'(fail), 32'd0);
        chk("rst_relock", 32'(relock_cnt), 32'd0);
        reset = 1'b0;
        pulse_width(n);
        chk("pwr_pulse", 32'(n), 32'd4);
        wait_locked(m);
        chk("pwr_lock_latency", 32'(m), 32'd11);
        chk("pwr_busy", 32'(busy), 32'd0);
        chk("pwr_icpsel", 32'(icpsel), 32'd20);

        // One-cycle lock loss while locked
        lock_mode = 0; lock_val = 1'b0;
        tick();
        lock_mode = 1;
        wait_rst();
        chk("drop_relock", 32'(relock_cnt), 32'd1);
        chk("drop_locked", 32'(locked), 32'd0);
        chk("drop_icpsel", 32'(icpsel), 32'd20);
        pulse_width(n);
        chk("drop_pulse", 32'(n), 32'd4);
        wait_locked(m);
        chk("drop_lock_latency", 32'(m), 32'd11);

        // cfg_req coinciding with lock loss, then async reset mid-WAIT
        lock_mode = 0; lock_val = 1'b0;
        tick(); tick(); tick();
        chk("pre_req_locked", 32'(locked), 32'd1);
        cfg_req = 1'b1; cfg_sel = 2'd3;
        tick();
        chk("req_relock_kept", 32'(relock_cnt), 32'd1);
        chk("req_cur_cfg", 32'(cur_cfg), 32'd3);
        chk("req_icpsel", 32'(icpsel), 32'd8);
        chk("req_lpfres", 32'(lpfres), 32'd4);
        chk("req_lpfcap", 32'(lpfcap), 32'd2);
        chk("req_locked", 32'(locked), 32'd0);
        pulse_width(n);
        tick(); tick();
        #2 reset = 1'b1;
        #1 check_model();
        chk("midrst_relock", 32'(relock_cnt), 32'd0);
        chk("midrst_cur_cfg", 32'(cur_cfg), 32'd0);
        chk("midrst_icpsel", 32'(icpsel), 32'd20);
        chk("midrst_pll_reset", 32'(pll_reset), 32'd1);
        @(negedge clkin);
        reset = 1'b0;

        // No lock at all: two tries per profile in order, then FAIL
        for (int k = 0; k < 8; k++) begin
            chk("sweep_rst", 32'(pll_reset), 32'd1);
            chk("sweep_icpsel", 32'(icpsel), 32'(exp_icp[k]));
            pulse_width(n);
            chk("sweep_pulse", 32'(n), 32'd4);
            low = 0;
            while (pll_reset === 1'b0 && low < 100) begin low++; tick(); end
            chk("sweep_wait_len", 32'(low), 32'(LT + 1));
        end
        chk("sweep_fail", 32'(fail), 32'd1);
        chk("sweep_busy", 32'(busy), 32'd0);
        repeat (5) tick();

        // Leave FAIL via cfg_req selecting profile 2
        lock_mode = 1;
        cfg_req = 1'b1; cfg_sel = 2'd2;
        tick();
        chk("fail_exit_fail", 32'(fail), 32'd0);
        chk("fail_exit_cfg", 32'(cur_cfg), 32'd2);
        chk("fail_exit_icpsel", 32'(icpsel), 32'd28);
        chk("fail_exit_lpfres", 32'(lpfres), 32'd1);
        chk("fail_exit_lpfcap", 32'(lpfcap), 32'd1);
        pulse_width(n);
        chk("fail_exit_pulse", 32'(n), 32'd4);
        wait_locked(m);
        chk("fail_exit_latency", 32'(m), 32'd11);

        // 3-cycle lock glitch in WAIT: retry stays on profile 0
        do_reset();
        lock_mode = 0; lock_val = 1'b0;
        pulse_width(n);
        lock_val = 1'b1;
        tick(); tick(); tick();
        lock_val = 1'b0;
        wait_rst();
        chk("glitch_icpsel", 32'(icpsel), 32'd20);
        chk("glitch_cfg", 32'(cur_cfg), 32'd0);
        pulse_width(n);
        wait_rst();
        chk("glitch_next_icpsel", 32'(icpsel), 32'd12);
        chk("glitch_next_cfg", 32'(cur_cfg), 32'd1);

        // Randomized lock behaviour and configuration requests
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) lock_mode = ($urandom_range(0, 3) == 0) ? 3 : 2;
            tick();
            if ($urandom_range(0, 199) == 0) begin
                cfg_req = 1'b1;
                cfg_sel = 2'($urandom_range(0, 3));
            end
        end

        // Relock counter saturation
        do_reset();
        lock_mode = 1;
        wait_locked(m);
        for (int i = 0; i < 258; i++) begin
            lock_mode = 0; lock_val = 1'b0;
            tick();
            lock_mode = 1;
            wait_rst();
            wait_locked(m);
        end
        chk("relock_saturated", 32'(relock_cnt), 32'd255);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
